div_rs_array: RTL and testbench
===============================

# div_rs_array

Parametrised divide reservation station for the out-of-order core's execution stage. It holds DEPTH pending RV32M divide/remainder ops (DIV, DIVU, REM, REMU) and snoops NCDB result buses for missing operands. It issues the oldest ready entry to one shared iterative radix-2 divider that supports signed and unsigned operation. Results are presented to the CDB arbiter with a valid/ready handshake; an entry frees only when its result is accepted.

## Interface
- XLEN, 32, operand/result width (even, ≥8)
- TAG_W, 5, ROB/register tag width; tag 0 = "operand present"
- DEPTH, 2, number of station entries (1..8)
- NCDB, 3, number of snooped result channels
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- iq_valid  in  1  dispatch request from issue queue
- iq_ready  out  1  at least one entry free; dispatch accepted when iq_valid && iq_ready
- iq_dest  in  TAG_W  destination tag
- iq_tag1, iq_tag2  in  TAG_W  pending source tags (0 = value valid)
- iq_src1, iq_src2  in  XLEN  source values (used when tag is 0)
- iq_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- cdb_tag  in  NCDB*TAG_W  channel k tag in bits [k*TAG_W +: TAG_W]; 0 = idle
- cdb_data  in  NCDB*XLEN  channel k data
- out_valid  out  1  result available
- out_ready  in  1  CDB arbiter grant
- out_tag  out  TAG_W  destination tag of result (0 when !out_valid)
- out_data  out  XLEN  result (0 when !out_valid)
- free_cnt  out  $clog2(DEPTH+1)  number of free entries

## Operation
- Entry state: valid, issued, dest, tag1/tag2, src1/src2, funct3, age.
- Dispatch: write into the lowest-index free entry. For each source with nonzero tag, compare against all CDB channels in the same cycle. On a match, capture the data and store tag 0 (dispatch-cycle bypass).
- Wakeup: every cycle, each valid entry's nonzero tag is compared with every channel. On a match, capture the data and clear the tag. On multiple matching channels, the lowest channel index wins.
- Age: a saturating per-entry counter, reset to 0 at dispatch and incremented each cycle while waiting. Selection picks the valid, unissued entry with both tags 0 and the highest age; ties go to the lowest index.
- Divider FSM: IDLE, CALC, DONE.
  - IDLE → CALC when a selected entry exists. Latch the operands and set the entry's issued bit.
  - IDLE → DONE directly on a special case.
  - CALC runs exactly XLEN cycles with a restoring shift-subtract, one quotient bit per cycle, then → DONE.
  - DONE holds out_valid with stable tag/data until out_ready. Then → IDLE, and the entry is freed.
- Signed ops (funct3[0]=0): divide the magnitudes. Negate the quotient when the sign bits differ. The remainder takes the dividend's sign.
- Special cases per RISC-V M, with no CALC cycles:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed MIN / -1: quotient MIN, remainder 0.
- funct3[2]=0 (not a divide op): result 0, no CALC.
- Output select: funct3[1]=0 → quotient, 1 → remainder.

## Timing
- Reset: all entries invalid, FSM IDLE, ages 0, out_valid 0, out_tag 0, out_data 0. iq_ready = 1 and free_cnt = DEPTH from the first cycle after reset. Reset mid-CALC or mid-DONE discards all work; no output is produced.
- iq_ready and free_cnt derive from registered state only. A slot freed by acceptance in cycle t is dispatchable in t+1, not in t.
- Normal latency: dispatch with ready operands at edge t → selected in cycle t+1 → CALC cycles t+2..t+XLEN+1 → out_valid in cycle t+XLEN+2.
- Special-case latency: out_valid in cycle t+2.
- An operand woken by CDB at edge t makes its entry selectable in cycle t+1.
- Back-to-back: on acceptance in cycle t (FSM → IDLE at the end of t), the next ready entry is selected in t+1. Maximum throughput is one result per XLEN+2 cycles.
- out_valid is not dropped without acceptance; data must not change while out_valid && !out_ready.
- Full station (free_cnt=0): iq_ready=0. iq_valid is ignored and no state changes.

## Test plan
- DIVU 100/7, both tags 0, out_ready=1 → out_valid exactly XLEN+2 cycles after dispatch with out_data=14; same operands as REMU → 2; out_tag = iq_dest.
- DIV -7/2 → -3 (0xFFFFFFFD); REM -7/2 → -1; DIV 0x80000000/-1 → 0x80000000, latency 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Dispatch with tag1=9 pending, then drive cdb channel 2 tag 9 data 40 → divide starts the next cycle. Repeat with the CDB match in the dispatch cycle itself → no extra wait.
- Fill DEPTH entries, the older one waiting on an operand → iq_ready=0, free_cnt=0. The younger ready entry issues first. Hold out_ready=0 for 5 cycles → out_valid and data stable, no new issue. Assert out_ready → free_cnt increments the next cycle.
- Two entries ready together, with ages 3 and 1 → the age-3 entry issues first. Assert reset mid-CALC → out_valid=0 and free_cnt=DEPTH on the next cycle, and no stale result appears afterwards.

Source files
------------

// File: rtl/div_rs_array.sv
// div_rs_array: divide reservation station feeding one shared radix-2 restoring divider.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   iq_valid/iq_ready          dispatch handshake from the issue queue
//   iq_dest, iq_tag1/2         destination tag and pending source tags (0 = value present)
//   iq_src1/2, iq_funct3       source values and RV32M funct3 (DIV/DIVU/REM/REMU)
//   cdb_tag, cdb_data          NCDB snooped result channels, channel k in slice k
//   out_valid/out_ready        result handshake towards the CDB arbiter
//   out_tag, out_data          result tag and value (0 when idle)
//   free_cnt                   number of free station entries
module div_rs_array #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2,
    parameter int NCDB  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       iq_valid,
    output logic                       iq_ready,
    input  logic [TAG_W-1:0]           iq_dest,
    input  logic [TAG_W-1:0]           iq_tag1,
    input  logic [TAG_W-1:0]           iq_tag2,
    input  logic [XLEN-1:0]            iq_src1,
    input  logic [XLEN-1:0]            iq_src2,
    input  logic [2:0]                 iq_funct3,
    input  logic [NCDB*TAG_W-1:0]      cdb_tag,
    input  logic [NCDB*XLEN-1:0]       cdb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [XLEN-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] free_cnt
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int AGE_W = 4;
    localparam int CNT_W = $clog2(XLEN);
    localparam int FC_W  = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Returns {hit, data}; iterating downwards lets the lowest matching channel win.
    function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] tag,
                                            input logic [NCDB*TAG_W-1:0] ctag,
                                            input logic [NCDB*XLEN-1:0] cdata);
        snoop = '0;
        for (int k = NCDB - 1; k >= 0; k--)
            if (tag != '0 && ctag[k*TAG_W +: TAG_W] == tag)
                snoop = {1'b1, cdata[k*XLEN +: XLEN]};
    endfunction

    logic [DEPTH-1:0] e_valid, e_issued;
    logic [TAG_W-1:0] e_dest [DEPTH];
    logic [TAG_W-1:0] e_tag1 [DEPTH];
    logic [TAG_W-1:0] e_tag2 [DEPTH];
    logic [XLEN-1:0]  e_src1 [DEPTH];
    logic [XLEN-1:0]  e_src2 [DEPTH];
    logic [2:0]       e_funct3 [DEPTH];
    logic [AGE_W-1:0] e_age [DEPTH];
    logic [XLEN:0]    wk1 [DEPTH];
    logic [XLEN:0]    wk2 [DEPTH];
    logic [XLEN:0]    disp1, disp2;
    logic [IDX_W-1:0] ins_idx, sel_idx, cur;
    logic             sel_found, accept, start, done_acc;
    logic [AGE_W-1:0] sel_age;

    state_t            state, state_nx;
    logic [XLEN-1:0]   q, r, d, q_nx, r_nx, res, res_fin;
    logic [XLEN:0]     r_sh, diff;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q, neg_r, sel_rem, last;
    logic [TAG_W-1:0]  res_tag;

    logic [XLEN-1:0] sel_a, sel_b, a_mag, b_mag, spec_res;
    logic [2:0]      sel_f;
    logic            signed_op, a_neg, b_neg, non_div, div0, ovf, spec;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_wake
            assign wk1[i] = e_valid[i] ? snoop(e_tag1[i], cdb_tag, cdb_data) : '0;
            assign wk2[i] = e_valid[i] ? snoop(e_tag2[i], cdb_tag, cdb_data) : '0;
        end
    endgenerate

    assign disp1 = snoop(iq_tag1, cdb_tag, cdb_data);
    assign disp2 = snoop(iq_tag2, cdb_tag, cdb_data);

    always_comb begin
        free_cnt = '0;
        ins_idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (!e_valid[k]) begin
                free_cnt = free_cnt + FC_W'(1);
                ins_idx  = IDX_W'(k);
            end
    end

    // Strict '>' keeps the lowest index among equally old candidates.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int k = 0; k < DEPTH; k++)
            if (e_valid[k] && !e_issued[k] && e_tag1[k] == '0 && e_tag2[k] == '0 &&
                (!sel_found || e_age[k] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
                sel_age   = e_age[k];
            end
    end

    assign iq_ready = free_cnt != '0;
    assign accept   = iq_valid && iq_ready;
    assign start    = state == IDLE && sel_found;
    assign done_acc = state == DONE && out_ready;

    assign sel_a     = e_src1[sel_idx];
    assign sel_b     = e_src2[sel_idx];
    assign sel_f     = e_funct3[sel_idx];
    assign signed_op = !sel_f[0];
    assign a_neg     = signed_op && sel_a[XLEN-1];
    assign b_neg     = signed_op && sel_b[XLEN-1];
    assign a_mag     = a_neg ? -sel_a : sel_a;
    assign b_mag     = b_neg ? -sel_b : sel_b;
    assign non_div   = !sel_f[2];
    assign div0      = sel_b == '0;
    assign ovf       = signed_op && sel_a == MIN && sel_b == '1;
    assign spec      = non_div || div0 || ovf;
    assign spec_res  = non_div ? '0 : div0 ? (sel_f[1] ? sel_a : '1) : (sel_f[1] ? '0 : MIN);

    // One restoring step: the partial remainder stays below d, so XLEN+1 bits suffice.
    assign r_sh    = {r, q[XLEN-1]};
    assign diff    = r_sh - {1'b0, d};
    assign r_nx    = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign q_nx    = {q[XLEN-2:0], ~diff[XLEN]};
    assign last    = cnt == CNT_W'(XLEN - 1);
    assign res_fin = sel_rem ? (neg_r ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb
        state_nx = start ? (spec ? DONE : CALC) :
                   (state == CALC && last) ? DONE :
                   done_acc ? IDLE : state;

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            r       <= '0;
            d       <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            res     <= '0;
            res_tag <= '0;
            cur     <= '0;
        end else if (start) begin
            q       <= a_mag;
            r       <= '0;
            d       <= b_mag;
            cnt     <= '0;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            sel_rem <= sel_f[1];
            res     <= spec_res;
            res_tag <= e_dest[sel_idx];
            cur     <= sel_idx;
        end else if (state == CALC) begin
            q   <= q_nx;
            r   <= r_nx;
            cnt <= cnt + CNT_W'(1);
            if (last)
                res <= res_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid  <= '0;
            e_issued <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                e_dest[k]   <= '0;
                e_tag1[k]   <= '0;
                e_tag2[k]   <= '0;
                e_src1[k]   <= '0;
                e_src2[k]   <= '0;
                e_funct3[k] <= '0;
                e_age[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (accept && ins_idx == IDX_W'(k)) begin
                    e_valid[k]  <= 1'b1;
                    e_issued[k] <= 1'b0;
                    e_dest[k]   <= iq_dest;
                    e_funct3[k] <= iq_funct3;
                    e_age[k]    <= '0;
                    e_tag1[k]   <= disp1[XLEN] ? '0 : iq_tag1;
                    e_tag2[k]   <= disp2[XLEN] ? '0 : iq_tag2;
                    e_src1[k]   <= disp1[XLEN] ? disp1[XLEN-1:0] : iq_src1;
                    e_src2[k]   <= disp2[XLEN] ? disp2[XLEN-1:0] : iq_src2;
                end else begin
                    if (wk1[k][XLEN]) begin
                        e_tag1[k] <= '0;
                        e_src1[k] <= wk1[k][XLEN-1:0];
                    end
                    if (wk2[k][XLEN]) begin
                        e_tag2[k] <= '0;
                        e_src2[k] <= wk2[k][XLEN-1:0];
                    end
                    if (e_valid[k] && !e_issued[k] && e_age[k] != '1)
                        e_age[k] <= e_age[k] + AGE_W'(1);
                    if (start && sel_idx == IDX_W'(k))
                        e_issued[k] <= 1'b1;
                    if (done_acc && cur == IDX_W'(k))
                        e_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = state == DONE;
    assign out_tag   = out_valid ? res_tag : '0;
    assign out_data  = out_valid ? res : '0;
endmodule

// File: tb/tb_div_rs_array.sv
// tb_div_rs_array: directed and randomized checks of div_rs_array against an arithmetic reference.
module tb_div_rs_array;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int DEPTH = 2;
    localparam int NCDB  = 3;
    localparam int NOPS  = 60;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  iq_valid = 1'b0;
    logic                  iq_ready;
    logic [TAG_W-1:0]      iq_dest = '0, iq_tag1 = '0, iq_tag2 = '0;
    logic [XLEN-1:0]       iq_src1 = '0, iq_src2 = '0;
    logic [2:0]            iq_funct3 = '0;
    logic [NCDB*TAG_W-1:0] cdb_tag = '0;
    logic [NCDB*XLEN-1:0]  cdb_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [TAG_W-1:0]      out_tag;
    logic [XLEN-1:0]       out_data;
    logic [1:0]            free_cnt;

    div_rs_array #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .NCDB(NCDB)) dut (
        .clk(clk), .reset(reset),
        .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_dest(iq_dest),
        .iq_tag1(iq_tag1), .iq_tag2(iq_tag2), .iq_src1(iq_src1), .iq_src2(iq_src2),
        .iq_funct3(iq_funct3), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_data(out_data), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  t1, t2;
    } op_t;

    op_t         mq[$];
    op_t         op;
    int          n_checks = 0, n_errors = 0;
    int          n_disp = 0, n_done = 0, idx;
    logic        held, seen;
    logic [4:0]  h_tag;
    logic [31:0] h_data, v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF;
        if (!f[2]) return 32'd0;
        if (b == 32'd0) return f[1] ? a : 32'hFFFFFFFF;
        if (ovf) return f[1] ? 32'd0 : 32'h80000000;
        case (f[1:0])
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic logic hit(input logic [4:0] t, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (t != 5'd0)
            for (int k = NCDB - 1; k >= 0; k--)
                if (cdb_tag[k*TAG_W +: TAG_W] == t) begin
                    hit = 1'b1;
                    val = cdb_data[k*XLEN +: XLEN];
                end
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic dispatch(input logic [4:0] dest, input logic [4:0] t1, input logic [4:0] t2,
                            input logic [31:0] s1, input logic [31:0] s2, input logic [2:0] f);
        iq_valid  = 1'b1;
        iq_dest   = dest;
        iq_tag1   = t1;
        iq_tag2   = t2;
        iq_src1   = s1;
        iq_src2   = s2;
        iq_funct3 = f;
        tick;
        iq_valid  = 1'b0;
    endtask

    // Called just after the edge that started the operation; that edge counts as 1.
    task automatic expect_out(input string name, input int lat, input logic [4:0] tag, input logic [31:0] data);
        int n;
        n = 1;
        while (!out_valid && n < 200) begin
            tick;
            n++;
        end
        check({name, "_lat"}, n, lat);
        check({name, "_tag"}, out_tag, tag);
        check({name, "_data"}, out_data, data);
    endtask

    task automatic run_one(input string name, input logic [4:0] dest, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] f, input int lat, input logic [31:0] exp);
        dispatch(dest, 0, 0, a, b, f);
        expect_out(name, lat, dest, exp);
        tick;
        check({name, "_gone"}, out_valid, 0);
        check({name, "_free"}, free_cnt, DEPTH);
    endtask

    initial begin
        repeat (3) tick;
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_tag", out_tag, 0);
        check("rst_data", out_data, 0);
        check("rst_ready", iq_ready, 1);
        check("rst_free", free_cnt, DEPTH);

        run_one("divu", 5'd3, 32'd100, 32'd7, 3'b101, XLEN + 2, 32'd14);
        run_one("remu", 5'd3, 32'd100, 32'd7, 3'b111, XLEN + 2, 32'd2);
        run_one("div_neg", 5'd7, -32'sd7, 32'd2, 3'b100, XLEN + 2, 32'hFFFFFFFD);
        run_one("rem_neg", 5'd8, -32'sd7, 32'd2, 3'b110, XLEN + 2, 32'hFFFFFFFF);
        run_one("div_ovf", 5'd9, 32'h80000000, 32'hFFFFFFFF, 3'b100, 2, 32'h80000000);
        run_one("divu_z", 5'd10, 32'd5, 32'd0, 3'b101, 2, 32'hFFFFFFFF);
        run_one("remu_z", 5'd11, 32'd5, 32'd0, 3'b111, 2, 32'd5);
        run_one("non_div", 5'd12, 32'd5, 32'd3, 3'b011, 2, 32'd0);

        dispatch(5'd4, 5'd9, 5'd0, 32'hDEAD, 32'd8, 3'b101);
        repeat (3) tick;
        check("wake_wait", out_valid, 0);
        cdb_tag  = {5'd9, 5'd0, 5'd0};
        cdb_data = {32'd40, 32'd0, 32'd0};
        tick;
        cdb_tag  = '0;
        expect_out("wake", XLEN + 2, 5'd4, 32'd5);
        tick;

        cdb_tag  = {5'd9, 5'd9, 5'd0};
        cdb_data = {32'd77, 32'd60, 32'd0};
        dispatch(5'd12, 5'd9, 5'd0, 32'h1234, 32'd6, 3'b101);
        cdb_tag  = '0;
        expect_out("bypass", XLEN + 2, 5'd12, 32'd10);
        tick;

        out_ready = 1'b0;
        dispatch(5'd5, 5'd12, 5'd0, 32'hBAD, 32'd3, 3'b101);
        dispatch(5'd6, 5'd0, 5'd0, 32'd50, 32'd5, 3'b101);
        check("full_ready", iq_ready, 0);
        check("full_free", free_cnt, 0);
        iq_valid = 1'b1;
        iq_dest  = 5'd7;
        iq_tag1  = 5'd0;
        iq_tag2  = 5'd0;
        iq_src1  = 32'd99;
        iq_src2  = 32'd1;
        expect_out("full_first", XLEN + 2, 5'd6, 32'd10);
        iq_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                cdb_tag  = {5'd0, 5'd0, 5'd12};
                cdb_data = {32'd0, 32'd0, 32'd33};
            end
            tick;
            cdb_tag = '0;
            check("hold_valid", out_valid, 1);
            check("hold_tag", out_tag, 5'd6);
            check("hold_data", out_data, 32'd10);
        end
        out_ready = 1'b1;
        #1;
        check("free_same_cycle", iq_ready, 0);
        tick;
        check("free_after_acc", free_cnt, 1);
        expect_out("full_second", XLEN + 2, 5'd5, 32'd11);
        tick;
        check("full_free_end", free_cnt, DEPTH);

        dispatch(5'd8, 5'd0, 5'd0, 32'd9, 32'd3, 3'b101);
        dispatch(5'd9, 5'd13, 5'd0, 32'hBAD, 32'd4, 3'b101);
        expect_out("age_x", XLEN + 1, 5'd8, 32'd3);
        tick;
        check("age_free", free_cnt, 1);
        dispatch(5'd10, 5'd14, 5'd0, 32'hBAD, 32'd5, 3'b101);
        tick;
        cdb_tag  = {5'd0, 5'd14, 5'd13};
        cdb_data = {32'd0, 32'd30, 32'd20};
        tick;
        cdb_tag  = '0;
        expect_out("age_old", XLEN + 2, 5'd9, 32'd5);
        tick;
        expect_out("age_young", XLEN + 2, 5'd10, 32'd6);
        tick;

        dispatch(5'd11, 5'd0, 5'd0, 32'd1000, 32'd7, 3'b101);
        repeat (5) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_free", free_cnt, DEPTH);
        check("mid_rst_ready", iq_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        check("no_stale", seen, 0);

        held = 1'b0;
        for (int cyc = 0; cyc < 20000 && n_done < NOPS; cyc++) begin
            for (int k = 0; k < NCDB; k++) begin
                cdb_tag[k*TAG_W +: TAG_W] = ($urandom_range(0, 2) == 0) ? 5'(20 + 4 * k + $urandom_range(0, 3)) : 5'd0;
                cdb_data[k*XLEN +: XLEN]  = rval();
            end
            out_ready = $urandom_range(0, 9) < 7;
            iq_valid  = 1'b0;
            if (n_disp < NOPS && iq_ready && $urandom_range(0, 1) == 1) begin
                iq_valid  = 1'b1;
                iq_dest   = 5'(1 + n_disp % 19);
                iq_tag1   = $urandom_range(0, 1) == 1 ? 5'(20 + $urandom_range(0, 11)) : 5'd0;
                iq_tag2   = $urandom_range(0, 1) == 1 ? 5'(20 + $urandom_range(0, 11)) : 5'd0;
                iq_src1   = rval();
                iq_src2   = rval();
                iq_funct3 = {$urandom_range(0, 7) != 0, 2'($urandom_range(0, 3))};
                n_disp++;
            end
            foreach (mq[j]) begin
                if (hit(mq[j].t1, v)) begin
                    mq[j].a  = v;
                    mq[j].t1 = 5'd0;
                end
                if (hit(mq[j].t2, v)) begin
                    mq[j].b  = v;
                    mq[j].t2 = 5'd0;
                end
            end
            if (iq_valid) begin
                op.dest = iq_dest;
                op.f    = iq_funct3;
                op.a    = iq_src1;
                op.b    = iq_src2;
                op.t1   = iq_tag1;
                op.t2   = iq_tag2;
                if (hit(iq_tag1, v)) begin
                    op.a  = v;
                    op.t1 = 5'd0;
                end
                if (hit(iq_tag2, v)) begin
                    op.b  = v;
                    op.t2 = 5'd0;
                end
                mq.push_back(op);
            end
            if (held) begin
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_tag", out_tag, h_tag);
                check("rnd_hold_data", out_data, h_data);
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    idx = -1;
                    foreach (mq[j])
                        if (mq[j].dest == out_tag) idx = j;
                    check("rnd_known", idx >= 0, 1);
                    if (idx >= 0) begin
                        check("rnd_pend", {mq[idx].t1, mq[idx].t2}, 0);
                        check("rnd_data", out_data, ref_op(mq[idx].f, mq[idx].a, mq[idx].b));
                        mq.delete(idx);
                    end
                    n_done++;
                end else begin
                    held   = 1'b1;
                    h_tag  = out_tag;
                    h_data = out_data;
                end
            end
            tick;
        end
        iq_valid = 1'b0;
        cdb_tag  = '0;
        check("rnd_done", n_done, NOPS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
